clkgen_drp_ctrl: RTL and testbench

CLKGEN_DRP_CTRL -- requirements
Module: clkgen_drp_ctrl

---
 rtl/clkgen_drp_ctrl.sv | 121 ++++++++++++
 tb/tb_clkgen_drp_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_drp_ctrl.sv
// DRP access controller for the clock generator: one register-triggered
// read/write per request, with a ready timeout and lock synchronizer.
module clkgen_drp_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        up_drp_req,
  input  logic        up_drp_rwn,
  input  logic [11:0] up_drp_addr,
  input  logic [15:0] up_drp_wdata,
  output logic        up_drp_status,
  output logic [15:0] up_drp_rdata,
  output logic        up_drp_timeout,
  output logic        up_mmcm_locked,
  output logic        drp_sel,
  output logic        drp_wr,
  output logic [11:0] drp_addr,
  output logic [15:0] drp_wdata,
  input  logic [15:0] drp_rdata,
  input  logic        drp_ready,
  input  logic        drp_locked
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  // Counter holds 0 in the first WAIT cycle, so the last one sees T-1.
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        rwn_q;
  logic [11:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        sel_q;
  logic        wr_q;
  logic        busy_q;
  logic        tmo_q;
  logic        lock_meta_q;
  logic        lock_sync_q;

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rwn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      sel_q <= 1'b0;
      wr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (up_drp_req) begin
            rwn_q   <= up_drp_rwn;
            addr_q  <= up_drp_addr;
            wdata_q <= up_drp_wdata;
            sel_q   <= 1'b1;
            wr_q    <= ~up_drp_rwn;
            busy_q  <= 1'b1;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (drp_ready) begin
            if (rwn_q) begin
              rdata_q <= drp_rdata;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == CntLast) begin
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= drp_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign drp_sel        = sel_q;
  assign drp_wr         = wr_q;
  assign drp_addr       = addr_q;
  assign drp_wdata      = wdata_q;
  assign up_drp_status  = busy_q;
  assign up_drp_rdata   = rdata_q;
  assign up_drp_timeout = tmo_q;
  assign up_mmcm_locked = lock_sync_q;

endmodule

// File: tb/tb_clkgen_drp_ctrl.sv
// Bench for clkgen_drp_ctrl: vector table, directed corner sequences and
// random traffic against a cycle-index transaction model.
module tb_clkgen_drp_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstn, req, rwn;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        status;
  logic [15:0] rdata;
  logic        tmo, lockd;
  logic        sel, wr;
  logic [11:0] daddr;
  logic [15:0] dwdata;
  logic [15:0] drdata;
  logic        ready, locked;

  always #5 clk = ~clk;

  clkgen_drp_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .up_clk        (clk),
    .up_rstn       (rstn),
    .up_drp_req    (req),
    .up_drp_rwn    (rwn),
    .up_drp_addr   (addr),
    .up_drp_wdata  (wdata),
    .up_drp_status (status),
    .up_drp_rdata  (rdata),
    .up_drp_timeout(tmo),
    .up_mmcm_locked(lockd),
    .drp_sel       (sel),
    .drp_wr        (wr),
    .drp_addr      (daddr),
    .drp_wdata     (dwdata),
    .drp_rdata     (drdata),
    .drp_ready     (ready),
    .drp_locked    (locked)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction model: a request accepted in cycle s gives sel in s+1,
  // may complete on ready in s+2.., and times out in cycle s+1+T.
  int          cyc = 0;
  bit          m_fl = 0;
  int          m_s = 0;
  logic        m_rwn = 1'b0;
  logic [11:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  logic        m_to = 1'b0, m_sel = 1'b0, m_wr = 1'b0;
  logic        m_l1 = 1'b0, m_l2 = 1'b0;

  task automatic model_step();
    m_sel = 1'b0;
    m_wr  = 1'b0;
    if (!rstn) begin
      m_fl = 0; m_rwn = 1'b0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_to = 1'b0; m_l1 = 1'b0; m_l2 = 1'b0;
    end else begin
      m_l2 = m_l1;
      m_l1 = locked;
      if (m_fl) begin
        if (cyc >= m_s + 2 && ready) begin
          m_fl = 0;
          if (m_rwn) m_rdata = drdata;
        end else if (cyc == m_s + 1 + T) begin
          m_fl = 0;
          m_to = 1'b1;
        end
      end else if (req) begin
        m_fl = 1; m_s = cyc;
        m_rwn = rwn; m_addr = addr; m_wdata = wdata;
        m_to = 1'b0; m_sel = 1'b1; m_wr = ~rwn;
      end
    end
  endtask

  task automatic check_model();
    chk("m_sel", sel, m_sel);
    chk("m_wr", wr, m_wr);
    chk("m_addr", daddr, m_addr);
    chk("m_wdata", dwdata, m_wdata);
    chk("m_status", status, m_fl);
    chk("m_rdata", rdata, m_rdata);
    chk("m_timeout", tmo, m_to);
    chk("m_locked", lockd, m_l2);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  task automatic idle_in();
    req = 1'b0; rwn = 1'b0; addr = '0; wdata = '0;
    ready = 1'b0; drdata = '0;
  endtask

  typedef struct {
    logic        req, rwn;
    logic [11:0] a;
    logic [15:0] wd;
    logic        rdy;
    logic [15:0] rd;
    logic        e_sel, e_wr, e_st, e_to;
    logic [15:0] e_rd;
    logic [11:0] e_ad;
  } vec_t;

  vec_t tbl[20];
  int   nsel;

  initial begin
    tbl[0]  = '{1'b1,1'b0,12'h008,16'h1234,1'b0,16'h0000, 1'b1,1'b1,1'b1,1'b0,16'h0000,12'h008};
    tbl[1]  = '{1'b0,1'b0,12'h000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0000,12'h008};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{1'b0,1'b0,12'h000,16'h0000,1'b1,16'hFFFF, 1'b0,1'b0,1'b0,1'b0,16'h0000,12'h008};
    tbl[5]  = '{1'b1,1'b1,12'h016,16'h0000,1'b0,16'h0000, 1'b1,1'b0,1'b1,1'b0,16'h0000,12'h016};
    tbl[6]  = '{1'b0,1'b0,12'h000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0000,12'h016};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = '{1'b0,1'b0,12'h000,16'h0000,1'b1,16'hBEEF, 1'b0,1'b0,1'b0,1'b0,16'hBEEF,12'h016};
    tbl[10] = '{1'b0,1'b0,12'h000,16'h0000,1'b1,16'h1111, 1'b0,1'b0,1'b0,1'b0,16'hBEEF,12'h016};
    tbl[11] = '{1'b1,1'b0,12'h020,16'h5555,1'b0,16'h0000, 1'b1,1'b1,1'b1,1'b0,16'hBEEF,12'h020};
    tbl[12] = '{1'b0,1'b0,12'h000,16'h0000,1'b1,16'h2222, 1'b0,1'b0,1'b1,1'b0,16'hBEEF,12'h020};
    tbl[13] = '{1'b0,1'b0,12'h000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'hBEEF,12'h020};
    tbl[14] = tbl[13];
    tbl[15] = tbl[13];
    tbl[16] = '{1'b0,1'b0,12'h000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b1,16'hBEEF,12'h020};
    tbl[17] = '{1'b1,1'b1,12'h030,16'h0000,1'b0,16'h0000, 1'b1,1'b0,1'b1,1'b0,16'hBEEF,12'h030};
    tbl[18] = '{1'b0,1'b0,12'h000,16'h0000,1'b0,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'hBEEF,12'h030};
    tbl[19] = '{1'b0,1'b0,12'h000,16'h0000,1'b1,16'h0042, 1'b0,1'b0,1'b0,1'b0,16'h0042,12'h030};

    rstn = 1'b0; locked = 1'b0;
    idle_in();
    @(negedge clk);
    step();
    step();
    chk("rst_sel", sel, 1'b0);
    chk("rst_status", status, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_addr", daddr, 12'h0);
    chk("rst_timeout", tmo, 1'b0);
    chk("rst_locked", lockd, 1'b0);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      req = tbl[i].req; rwn = tbl[i].rwn; addr = tbl[i].a;
      wdata = tbl[i].wd; ready = tbl[i].rdy; drdata = tbl[i].rd;
      step();
      chk($sformatf("v%0d_sel", i), sel, tbl[i].e_sel);
      chk($sformatf("v%0d_wr", i), wr, tbl[i].e_wr);
      chk($sformatf("v%0d_status", i), status, tbl[i].e_st);
      chk($sformatf("v%0d_timeout", i), tmo, tbl[i].e_to);
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rd);
      chk($sformatf("v%0d_addr", i), daddr, tbl[i].e_ad);
    end
    idle_in();
    step();

    // Request during WAIT is dropped.
    nsel = 0;
    req = 1'b1; rwn = 1'b1; addr = 12'h040;
    step(); nsel += int'(sel);
    idle_in();
    step(); nsel += int'(sel);
    req = 1'b1; rwn = 1'b0; addr = 12'h0FF; wdata = 16'h9999;
    step(); nsel += int'(sel);
    idle_in();
    step(); nsel += int'(sel);
    ready = 1'b1; drdata = 16'h7777;
    step(); nsel += int'(sel);
    idle_in();
    step(); nsel += int'(sel);
    chk("ign_sel_count", nsel, 1);
    chk("ign_addr", daddr, 12'h040);
    chk("ign_rdata", rdata, 16'h7777);
    chk("ign_status", status, 1'b0);

    // Ready in the last WAIT cycle wins over timeout.
    req = 1'b1; rwn = 1'b1; addr = 12'h050;
    step();
    idle_in();
    repeat (4) step();
    chk("prio_busy", status, 1'b1);
    ready = 1'b1; drdata = 16'hABCD;
    step();
    idle_in();
    chk("prio_rdata", rdata, 16'hABCD);
    chk("prio_timeout", tmo, 1'b0);
    chk("prio_status", status, 1'b0);

    // Lock synchronizer latency.
    locked = 1'b1;
    step();
    chk("lock_rise_1", lockd, 1'b0);
    step();
    chk("lock_rise_2", lockd, 1'b1);
    locked = 1'b0;
    step();
    chk("lock_fall_1", lockd, 1'b1);
    step();
    chk("lock_fall_2", lockd, 1'b0);
    locked = 1'b1;
    step(); step();

    // Reset in WAIT aborts; late ready is ignored.
    req = 1'b1; rwn = 1'b1; addr = 12'h066; wdata = 16'h4321;
    step();
    idle_in();
    step();
    rstn = 1'b0; req = 1'b1; addr = 12'h077;
    step();
    chk("rstw_sel", sel, 1'b0);
    chk("rstw_wr", wr, 1'b0);
    chk("rstw_addr", daddr, 12'h0);
    chk("rstw_wdata", dwdata, 16'h0);
    chk("rstw_status", status, 1'b0);
    chk("rstw_rdata", rdata, 16'h0);
    chk("rstw_locked", lockd, 1'b0);
    rstn = 1'b1;
    idle_in();
    step();
    step();
    ready = 1'b1; drdata = 16'hDEAD;
    step();
    idle_in();
    chk("rstw_late_rdata", rdata, 16'h0);
    chk("rstw_late_status", status, 1'b0);
    chk("rstw_late_sel", sel, 1'b0);

    for (int i = 0; i < 600; i++) begin
      rstn   = ($urandom_range(0, 79) != 0);
      req    = ($urandom_range(0, 3) == 0);
      rwn    = 1'($urandom);
      addr   = 12'($urandom);
      wdata  = 16'($urandom);
      ready  = ($urandom_range(0, 4) == 0);
      drdata = 16'($urandom);
      if ($urandom_range(0, 9) == 0) locked = ~locked;
      step();
    end
    rstn = 1'b1;
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
